// File: rtl/yarp_lsu_if.sv
// rtl/yarp_lsu_if.sv - data-memory bus between yarp_lsu (master) and memory (slave)
interface yarp_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/yarp_lsu.sv
// rtl/yarp_lsu.sv - load/store unit with lane steering, extension and misalign detect
// Optional access timeout: define YARP_LSU_TIMEOUT_EN.
module yarp_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_req_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_wr_i,
  input  logic [31:0]       lsu_wr_data_i,
  input  logic              lsu_zero_extnd_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [31:0]       lsu_rd_data_o,
  output logic              lsu_misalign_o,
  output logic              lsu_err_o,
  yarp_lsu_if.master        mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("yarp_lsu: TIMEOUT_CYCLES must be >= 2");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic              zext_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              done_q, misalign_q, err_q;
  logic [31:0]       rd_data_q;

  logic              misaligned, accept, mis_det, complete, timeout;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic [31:0]       shifted, ld_data;

`ifdef YARP_LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q;
`endif

  always_comb begin
    misaligned = (lsu_size_i == 2'b10) ||
                 (lsu_size_i == SZ_HALF && lsu_addr_i[0]) ||
                 (lsu_size_i == SZ_WORD && lsu_addr_i[1:0] != 2'b00);
    case (lsu_size_i)
      SZ_BYTE: begin
        wdata_d = {4{lsu_wr_data_i[7:0]}};
        be_d    = 4'b0001 << lsu_addr_i[1:0];
      end
      SZ_HALF: begin
        wdata_d = {2{lsu_wr_data_i[15:0]}};
        be_d    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_d = lsu_wr_data_i;
        be_d    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted = mem.rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: ld_data = zext_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: ld_data = zext_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    mis_det  = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: if (lsu_req_i) begin
        if (misaligned) begin
          mis_det = 1'b1;
        end else begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ:  if (mem.gnt) state_d = WAIT;
      WAIT: if (mem.rvalid) begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef YARP_LSU_TIMEOUT_EN
    // A response arriving on the last allowed cycle still completes normally.
    if (state_q != IDLE && !complete && cnt_q == CNT_MAX) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      wr_q       <= 1'b0;
      zext_q     <= 1'b0;
      be_q       <= 4'b0;
      wdata_q    <= 32'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= 32'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= mis_det | complete | timeout;
      misalign_q <= mis_det;
      err_q      <= (complete & mem.err) | timeout;
      rd_data_q  <= (complete && !mem.err && !wr_q) ? ld_data : 32'b0;
      if (accept) begin
        addr_q  <= lsu_addr_i;
        size_q  <= lsu_size_i;
        wr_q    <= lsu_wr_i;
        zext_q  <= lsu_zero_extnd_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
    end
  end

`ifdef YARP_LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  assign lsu_busy_o     = (state_q != IDLE);
  assign lsu_done_o     = done_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_err_o      = err_q;
  assign lsu_rd_data_o  = rd_data_q;
  assign mem.req        = (state_q == REQ);
  assign mem.addr       = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.we         = wr_q;
  assign mem.be         = be_q;
  assign mem.wdata      = wdata_q;

endmodule

// File: tb/tb_yarp_lsu.sv
// tb/tb_yarp_lsu.sv - directed self-checking bench for yarp_lsu
module tb_yarp_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_wr_i;
  logic [31:0] lsu_wr_data_i;
  logic        lsu_zero_extnd_i;
  logic        lsu_busy_o, lsu_done_o, lsu_misalign_o, lsu_err_o;
  logic [31:0] lsu_rd_data_o;
  int          checks = 0;
  int          errors = 0;

  yarp_lsu_if #(.ADDR_W(32)) mem_if ();

  yarp_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .lsu_req_i        (lsu_req_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_wr_i         (lsu_wr_i),
    .lsu_wr_data_i    (lsu_wr_data_i),
    .lsu_zero_extnd_i (lsu_zero_extnd_i),
    .lsu_busy_o       (lsu_busy_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_rd_data_o    (lsu_rd_data_o),
    .lsu_misalign_o   (lsu_misalign_o),
    .lsu_err_o        (lsu_err_o),
    .mem              (mem_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic w,
                       input logic [31:0] d, input logic z);
    lsu_req_i        = 1'b1;
    lsu_addr_i       = a;
    lsu_size_i       = s;
    lsu_wr_i         = w;
    lsu_wr_data_i    = d;
    lsu_zero_extnd_i = z;
  endtask

  initial begin
    reset = 1'b1;
    lsu_req_i = 1'b0; lsu_addr_i = '0; lsu_size_i = 2'b00; lsu_wr_i = 1'b0;
    lsu_wr_data_i = '0; lsu_zero_extnd_i = 1'b0;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0; mem_if.err = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(lsu_busy_o), 32'd0);
    check("rst_done", 32'(lsu_done_o), 32'd0);
    check("rst_rdata", lsu_rd_data_o, 32'h0);
    check("rst_memreq", 32'(mem_if.req), 32'd0);
    check("rst_be", 32'(mem_if.be), 32'h0);
    reset = 1'b0;
    tick();

    // Load byte, sign-extended, minimum latency
    issue(32'h103, 2'b00, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    check("lb_req", 32'(mem_if.req), 32'd1);
    check("lb_addr", mem_if.addr, 32'h100);
    check("lb_we", 32'(mem_if.we), 32'd0);
    check("lb_busy", 32'(lsu_busy_o), 32'd1);
    mem_if.gnt = 1'b1;
    tick(); mem_if.gnt = 1'b0;
    check("lb_req_drop", 32'(mem_if.req), 32'd0);
    check("lb_wait_done", 32'(lsu_done_o), 32'd0);
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'h80FF_0000;
    tick(); mem_if.rvalid = 1'b0;
    check("lb_done", 32'(lsu_done_o), 32'd1);
    check("lb_rdata", lsu_rd_data_o, 32'hFFFF_FF80);
    check("lb_err", 32'(lsu_err_o), 32'd0);
    check("lb_busy_end", 32'(lsu_busy_o), 32'd0);
    tick();
    check("lb_done_pulse", 32'(lsu_done_o), 32'd0);

    // Store half on upper lanes
    issue(32'h202, 2'b01, 1'b1, 32'h1234_ABCD, 1'b0);
    tick(); lsu_req_i = 1'b0;
    check("sh_be", 32'(mem_if.be), 32'hC);
    check("sh_wdata", mem_if.wdata, 32'hABCD_ABCD);
    check("sh_we", 32'(mem_if.we), 32'd1);
    check("sh_addr", mem_if.addr, 32'h200);
    mem_if.gnt = 1'b1;
    tick(); mem_if.gnt = 1'b0;
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
    tick(); mem_if.rvalid = 1'b0;
    check("sh_done", 32'(lsu_done_o), 32'd1);
    check("sh_err", 32'(lsu_err_o), 32'd0);
    check("sh_rdata", lsu_rd_data_o, 32'h0);
    tick();

    // Misaligned word and illegal size
    issue(32'h301, 2'b11, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    check("mw_req", 32'(mem_if.req), 32'd0);
    check("mw_busy", 32'(lsu_busy_o), 32'd0);
    check("mw_done", 32'(lsu_done_o), 32'd1);
    check("mw_mis", 32'(lsu_misalign_o), 32'd1);
    check("mw_rdata", lsu_rd_data_o, 32'h0);
    tick();
    check("mw_mis_pulse", 32'(lsu_misalign_o), 32'd0);
    issue(32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    check("sz10_req", 32'(mem_if.req), 32'd0);
    check("sz10_done", 32'(lsu_done_o), 32'd1);
    check("sz10_mis", 32'(lsu_misalign_o), 32'd1);
    tick();

    // Load half zero-extended with delayed grant
    issue(32'h2, 2'b01, 1'b0, 32'h0, 1'b1);
    tick(); lsu_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("lhu_req_hold", 32'(mem_if.req), 32'd1);
      check("lhu_busy_hold", 32'(lsu_busy_o), 32'd1);
      tick();
    end
    check("lhu_req_6th", 32'(mem_if.req), 32'd1);
    mem_if.gnt = 1'b1;
    tick(); mem_if.gnt = 1'b0;
    check("lhu_req_drop", 32'(mem_if.req), 32'd0);
    check("lhu_busy_wait", 32'(lsu_busy_o), 32'd1);
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'hBEEF_0000;
    tick(); mem_if.rvalid = 1'b0;
    check("lhu_done", 32'(lsu_done_o), 32'd1);
    check("lhu_rdata", lsu_rd_data_o, 32'h0000_BEEF);
    tick();

    // Memory error response, then a back-to-back request in the done cycle
    issue(32'h10, 2'b11, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    mem_if.gnt = 1'b1;
    tick(); mem_if.gnt = 1'b0;
    mem_if.rvalid = 1'b1; mem_if.err = 1'b1; mem_if.rdata = 32'h1234_5678;
    tick(); mem_if.rvalid = 1'b0; mem_if.err = 1'b0;
    check("err_done", 32'(lsu_done_o), 32'd1);
    check("err_err", 32'(lsu_err_o), 32'd1);
    check("err_rdata", lsu_rd_data_o, 32'h0);
    issue(32'h20, 2'b11, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    check("b2b_req", 32'(mem_if.req), 32'd1);
    check("b2b_addr", mem_if.addr, 32'h20);
    mem_if.gnt = 1'b1;
    tick(); mem_if.gnt = 1'b0;

    // Reset while waiting for the response; late rvalid ignored
    reset = 1'b1;
    tick(); reset = 1'b0;
    check("rstw_busy", 32'(lsu_busy_o), 32'd0);
    check("rstw_req", 32'(mem_if.req), 32'd0);
    check("rstw_done", 32'(lsu_done_o), 32'd0);
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'hFFFF_FFFF;
    tick(); mem_if.rvalid = 1'b0;
    check("late_rv_done", 32'(lsu_done_o), 32'd0);
    check("late_rv_busy", 32'(lsu_busy_o), 32'd0);
    tick();

`ifdef YARP_LSU_TIMEOUT_EN
    issue(32'h40, 2'b11, 1'b0, 32'h0, 1'b0);
    tick(); lsu_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_req_hold", 32'(mem_if.req), 32'd1);
      tick();
    end
    check("to_req_drop", 32'(mem_if.req), 32'd0);
    check("to_done", 32'(lsu_done_o), 32'd1);
    check("to_err", 32'(lsu_err_o), 32'd1);
    check("to_rdata", lsu_rd_data_o, 32'h0);
    mem_if.rvalid = 1'b1;
    tick(); mem_if.rvalid = 1'b0;
    check("to_late_done", 32'(lsu_done_o), 32'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
